// File: rtl/line_tracker_pkg.sv
// Shared types and constants for the line-following control stage.
package line_tracker_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_FORWARD    = 3'd1,
      ST_TURN_LEFT  = 3'd2,
      ST_TURN_RIGHT = 3'd3,
      ST_SEARCH     = 3'd4,
      ST_STOP       = 3'd5
   } state_e;

   // mode[1] = left motor run, mode[0] = right motor run
   localparam logic [1:0] MODE_STOP       = 2'b00;
   localparam logic [1:0] MODE_RIGHT_TURN = 2'b10;
   localparam logic [1:0] MODE_LEFT_TURN  = 2'b01;
   localparam logic [1:0] MODE_FWD        = 2'b11;

   // States in which the car actively follows the line and pre_mode tracks mode.
   function automatic logic is_tracking(input state_e s);
      return (s == ST_FORWARD) || (s == ST_TURN_LEFT) || (s == ST_TURN_RIGHT);
   endfunction

   // Map the filtered {l,c,r} vector to a state; 101 is ambiguous and yields hold_s.
   function automatic state_e decode_line(input logic [2:0] lcr, input state_e hold_s);
      state_e res;
      case (lcr)
         3'b010, 3'b111: res = ST_FORWARD;
         3'b100, 3'b110: res = ST_TURN_LEFT;
         3'b001, 3'b011: res = ST_TURN_RIGHT;
         3'b000:         res = ST_SEARCH;
         default:        res = hold_s;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a stability counter for one raw IR sensor.
module sensor_debounce #(
   parameter int DEB_CYCLES = 100_000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic filt_o
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          filt_q;
   logic          filt_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Count consecutive cycles the synced value disagrees with the filtered one.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync_q[1] != filt_q) begin
         if (cnt_q == CNT_LAST) begin
            filt_d = sync_q[1];
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         cnt_d = '0;
      end
   end

   // Synchroniser, filtered value and debounce counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= 2'b00;
         filt_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], raw_i};
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign filt_o = filt_q;

endmodule

// File: rtl/line_tracker.sv
// Line-following controller: sensor filtering, tracking FSM, dead time and lost-line park.
module line_tracker
   import line_tracker_pkg::*;
#(
   parameter int DEB_CYCLES  = 100_000,
   parameter int LOST_CYCLES = 200_000_000,
   parameter int DEAD_CYCLES = 1_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       sensor_l,
   input  logic       sensor_c,
   input  logic       sensor_r,
   output logic [1:0] mode,
   output logic [1:0] pre_mode,
   output logic       en_left,
   output logic       en_right,
   output logic [2:0] state_dbg
);

   localparam int LW = (LOST_CYCLES > 1) ? $clog2(LOST_CYCLES) : 1;
   localparam int DW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
   localparam logic [LW-1:0] LOST_LAST = LW'(LOST_CYCLES - 1);
   localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES);

   logic          filt_l;
   logic          filt_c;
   logic          filt_r;
   logic [2:0]    lcr;

   state_e        state_q, state_d;
   logic [1:0]    mode_q, mode_d;
   logic [1:0]    pre_mode_q, pre_mode_d;
   logic [LW-1:0] lost_q, lost_d;
   logic [DW-1:0] dead_q, dead_d;
   logic          en_left_q, en_left_d;
   logic          en_right_q, en_right_d;

   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
      .clk(clk), .reset(reset), .raw_i(sensor_l), .filt_o(filt_l)
   );
   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_c (
      .clk(clk), .reset(reset), .raw_i(sensor_c), .filt_o(filt_c)
   );
   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
      .clk(clk), .reset(reset), .raw_i(sensor_r), .filt_o(filt_r)
   );

   assign lcr = {filt_l, filt_c, filt_r};

   // Next state, lost-line counter, remembered tracking mode and the mode it implies.
   always_comb begin
      state_d    = state_q;
      lost_d     = '0;
      pre_mode_d = pre_mode_q;
      mode_d     = MODE_STOP;

      if (is_tracking(state_q)) begin
         pre_mode_d = mode_q;
      end else begin
         pre_mode_d = pre_mode_q;
      end

      if (!run) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:       state_d = decode_line(lcr, ST_FORWARD);
            ST_FORWARD,
            ST_TURN_LEFT,
            ST_TURN_RIGHT: state_d = decode_line(lcr, state_q);
            ST_SEARCH: begin
               if (lcr == 3'b000) begin
                  if (lost_q == LOST_LAST) begin
                     state_d = ST_STOP;
                  end else begin
                     state_d = ST_SEARCH;
                     lost_d  = lost_q + LW'(1);
                  end
               end else begin
                  state_d = decode_line(lcr, ST_SEARCH);
               end
            end
            ST_STOP:       state_d = ST_STOP;
            default:       state_d = ST_IDLE;
         endcase
      end

      // Searching keeps steering the way the car was last heading.
      case (state_d)
         ST_FORWARD:    mode_d = MODE_FWD;
         ST_TURN_LEFT:  mode_d = MODE_LEFT_TURN;
         ST_TURN_RIGHT: mode_d = MODE_RIGHT_TURN;
         ST_SEARCH:     mode_d = pre_mode_d;
         default:       mode_d = MODE_STOP;
      endcase
   end

   // Dead-time counter and gated motor enables, reloaded on every mode change.
   always_comb begin
      dead_d = dead_q;
      if (mode_d != mode_q) begin
         dead_d = DEAD_LOAD;
      end else if (dead_q != '0) begin
         dead_d = dead_q - DW'(1);
      end else begin
         dead_d = dead_q;
      end

      if (dead_d == '0) begin
         en_left_d  = mode_d[1];
         en_right_d = mode_d[0];
      end else begin
         en_left_d  = 1'b0;
         en_right_d = 1'b0;
      end
   end

   // Controller state and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         mode_q     <= MODE_STOP;
         pre_mode_q <= MODE_FWD;
         lost_q     <= '0;
         dead_q     <= '0;
         en_left_q  <= 1'b0;
         en_right_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         pre_mode_q <= pre_mode_d;
         lost_q     <= lost_d;
         dead_q     <= dead_d;
         en_left_q  <= en_left_d;
         en_right_q <= en_right_d;
      end
   end

   assign mode      = mode_q;
   assign pre_mode  = pre_mode_q;
   assign en_left   = en_left_q;
   assign en_right  = en_right_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_line_tracker.sv
// Scoreboard bench for line_tracker with short debounce, lost and dead-time windows.
module tb_line_tracker;
   import line_tracker_pkg::*;

   localparam int DEB  = 4;
   localparam int LOST = 50;
   localparam int DEAD = 3;
   // Raw change driven after edge k: filtered at edge k+DEB+2, state/mode at k+DEB+3.
   localparam int LAT  = DEB + 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       run;
   logic       s_l, s_c, s_r;
   logic [1:0] mode, pre_mode;
   logic       en_left, en_right;
   logic [2:0] state_dbg;

   int cyc      = 0;
   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      int         cyc;
      logic [2:0] st;
      logic [1:0] md;
      logic [1:0] pm;
      logic       el;
      logic       er;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];

   line_tracker #(
      .DEB_CYCLES(DEB), .LOST_CYCLES(LOST), .DEAD_CYCLES(DEAD)
   ) dut (
      .clk(clk), .reset(reset), .run(run),
      .sensor_l(s_l), .sensor_c(s_c), .sensor_r(s_r),
      .mode(mode), .pre_mode(pre_mode),
      .en_left(en_left), .en_right(en_right),
      .state_dbg(state_dbg)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Edge counter used to time scoreboard entries.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_raw(input logic [2:0] lcr);
      {s_l, s_c, s_r} = lcr;
   endtask

   task automatic expect_at(input string tag, input int off, input logic [2:0] st,
                            input logic [1:0] md, input logic [1:0] pm,
                            input logic el, input logic er);
      exp_t e;
      e.cyc = cyc + off;
      e.st  = st;
      e.md  = md;
      e.pm  = pm;
      e.el  = el;
      e.er  = er;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic check_all(input string tag, input logic [2:0] st, input logic [1:0] md,
                            input logic [1:0] pm, input logic el, input logic er);
      check({tag, ".state"},    32'(state_dbg), 32'(st));
      check({tag, ".mode"},     32'(mode),      32'(md));
      check({tag, ".pre_mode"}, 32'(pre_mode),  32'(pm));
      check({tag, ".en_left"},  32'(en_left),   32'(el));
      check({tag, ".en_right"}, 32'(en_right),  32'(er));
   endtask

   // Pop and compare every scoreboard entry due on this cycle, away from the active edge.
   always @(negedge clk) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].cyc <= cyc) begin
            check({tag_q[i], ".due"}, 32'(exp_q[i].cyc), 32'(cyc));
            check_all(tag_q[i], exp_q[i].st, exp_q[i].md, exp_q[i].pm, exp_q[i].el, exp_q[i].er);
            exp_q.delete(i);
            tag_q.delete(i);
         end
      end
   end

   initial begin
      reset = 1'b1;
      run   = 1'b0;
      set_raw(3'b000);
      tick(3);
      check_all("reset", ST_IDLE, 2'b00, 2'b11, 1'b0, 1'b0);
      reset = 1'b0;
      tick(2);

      // Line seen while parked; start tracking once filtered.
      set_raw(3'b010);
      expect_at("idle_hold", 8, ST_IDLE, 2'b00, 2'b11, 1'b0, 1'b0);
      tick(10);
      run = 1'b1;
      expect_at("fwd_entry", 1, ST_FORWARD, 2'b11, 2'b11, 1'b0, 1'b0);
      expect_at("fwd_dead",  3, ST_FORWARD, 2'b11, 2'b11, 1'b0, 1'b0);
      expect_at("fwd_en",    4, ST_FORWARD, 2'b11, 2'b11, 1'b1, 1'b1);
      tick(6);

      // Glitch of DEB-1 cycles must not reach the filtered vector.
      set_raw(3'b100);
      expect_at("glitch_a", 2, ST_FORWARD, 2'b11, 2'b11, 1'b1, 1'b1);
      expect_at("glitch_b", 6, ST_FORWARD, 2'b11, 2'b11, 1'b1, 1'b1);
      expect_at("glitch_c", 9, ST_FORWARD, 2'b11, 2'b11, 1'b1, 1'b1);
      tick(3);
      set_raw(3'b010);
      tick(10);

      // Forward to left turn, with exact filter latency and dead time.
      set_raw(3'b110);
      expect_at("tl_early", LAT - 1, ST_FORWARD,   2'b11, 2'b11, 1'b1, 1'b1);
      expect_at("tl_entry", LAT,     ST_TURN_LEFT, 2'b01, 2'b11, 1'b0, 1'b0);
      expect_at("tl_pre",   LAT + 1, ST_TURN_LEFT, 2'b01, 2'b01, 1'b0, 1'b0);
      expect_at("tl_dead",  LAT + 2, ST_TURN_LEFT, 2'b01, 2'b01, 1'b0, 1'b0);
      expect_at("tl_en",    LAT + 3, ST_TURN_LEFT, 2'b01, 2'b01, 1'b0, 1'b1);
      tick(LAT + 5);

      // Right turn, then line lost until the car parks.
      set_raw(3'b011);
      expect_at("tr_entry", LAT,     ST_TURN_RIGHT, 2'b10, 2'b01, 1'b0, 1'b0);
      expect_at("tr_en",    LAT + 3, ST_TURN_RIGHT, 2'b10, 2'b10, 1'b1, 1'b0);
      tick(LAT + 5);
      set_raw(3'b000);
      expect_at("srch_entry", LAT,             ST_SEARCH, 2'b10, 2'b10, 1'b1, 1'b0);
      expect_at("srch_last",  LAT + LOST - 1,  ST_SEARCH, 2'b10, 2'b10, 1'b1, 1'b0);
      expect_at("stop_entry", LAT + LOST,      ST_STOP,   2'b00, 2'b10, 1'b0, 1'b0);
      expect_at("stop_hold",  LAT + LOST + 10, ST_STOP,   2'b00, 2'b10, 1'b0, 1'b0);
      tick(LAT + LOST + 12);
      run = 1'b0;
      expect_at("stop_idle", 1, ST_IDLE, 2'b00, 2'b10, 1'b0, 1'b0);
      tick(1);
      set_raw(3'b010);
      tick(LAT + 3);
      run = 1'b1;
      expect_at("restart",     1, ST_FORWARD, 2'b11, 2'b10, 1'b0, 1'b0);
      expect_at("restart_pre", 2, ST_FORWARD, 2'b11, 2'b11, 1'b0, 1'b0);
      expect_at("restart_en",  4, ST_FORWARD, 2'b11, 2'b11, 1'b1, 1'b1);
      tick(6);

      // Line recovered 20 cycles into SEARCH; no park afterwards.
      set_raw(3'b000);
      expect_at("srch2_entry", LAT, ST_SEARCH, 2'b11, 2'b11, 1'b1, 1'b1);
      tick(LAT + 20);
      set_raw(3'b001);
      expect_at("srch2_hold",    LAT - 1,   ST_SEARCH,     2'b11, 2'b11, 1'b1, 1'b1);
      expect_at("srch2_exit",    LAT,       ST_TURN_RIGHT, 2'b10, 2'b11, 1'b0, 1'b0);
      expect_at("srch2_exit_en", LAT + 3,   ST_TURN_RIGHT, 2'b10, 2'b10, 1'b1, 1'b0);
      expect_at("no_stop",       LOST + 10, ST_TURN_RIGHT, 2'b10, 2'b10, 1'b1, 1'b0);
      tick(LOST + 12);

      // Fresh SEARCH must again last the full window.
      set_raw(3'b000);
      expect_at("srch3_entry", LAT,            ST_SEARCH, 2'b10, 2'b10, 1'b1, 1'b0);
      expect_at("srch3_last",  LAT + LOST - 1, ST_SEARCH, 2'b10, 2'b10, 1'b1, 1'b0);
      expect_at("srch3_stop",  LAT + LOST,     ST_STOP,   2'b00, 2'b10, 1'b0, 1'b0);
      tick(LAT + LOST + 2);
      run = 1'b0;
      tick(2);

      // Ambiguous 101 from IDLE goes forward.
      set_raw(3'b101);
      tick(LAT + 2);
      run = 1'b1;
      expect_at("idle_101",    1, ST_FORWARD, 2'b11, 2'b10, 1'b0, 1'b0);
      expect_at("idle_101_en", 4, ST_FORWARD, 2'b11, 2'b11, 1'b1, 1'b1);
      tick(6);

      // Back-to-back mode changes: dead time restarts from the second change.
      set_raw(3'b010);
      tick(LAT + 2);
      set_raw(3'b110);
      expect_at("rl_tl",    LAT,     ST_TURN_LEFT, 2'b01, 2'b11, 1'b0, 1'b0);
      expect_at("rl_fwd",   LAT + 1, ST_FORWARD,   2'b11, 2'b01, 1'b0, 1'b0);
      expect_at("rl_dead1", LAT + 2, ST_FORWARD,   2'b11, 2'b11, 1'b0, 1'b0);
      expect_at("rl_dead2", LAT + 3, ST_FORWARD,   2'b11, 2'b11, 1'b0, 1'b0);
      expect_at("rl_en",    LAT + 4, ST_FORWARD,   2'b11, 2'b11, 1'b1, 1'b1);
      tick(1);
      set_raw(3'b111);
      tick(LAT + 5);

      // Ambiguous 101 while running holds the current state.
      set_raw(3'b101);
      expect_at("run_101_hold", LAT + 2, ST_FORWARD, 2'b11, 2'b11, 1'b1, 1'b1);
      tick(LAT + 4);

      // Asynchronous reset mid-run clears outputs and the debounced vector.
      reset = 1'b1;
      #2;
      check_all("midrun_reset", ST_IDLE, 2'b00, 2'b11, 1'b0, 1'b0);
      tick(2);
      reset = 1'b0;
      expect_at("post_rst",    1, ST_SEARCH, 2'b11, 2'b11, 1'b0, 1'b0);
      expect_at("post_rst_en", 4, ST_SEARCH, 2'b11, 2'b11, 1'b1, 1'b1);
      tick(6);

      for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick(1);
      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
